multi_cycle_controller: RTL and testbench

Finite-state control sequencer that drives the team's RV32I datapath in multi-cycle form: one shared ALU, one unified instruction/data memory port, and IR/MDR/A/B/ALUOut holding registers. It decodes the latched opcode and steps each instruction through FETCH → DECODE → execute → memory → write-back states. It emits every mux select and write strobe for the datapath, stalls on a memory-ready handshake, and raises `is_halted` on a halting ECALL.

---
 rtl/multi_cycle_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller.sv
// -----------------------------------------------------------------------------
// multi_cycle_controller
//
// Control sequencer for the multi-cycle RV32I datapath. The datapath has one
// shared ALU, one unified instruction/data memory port, and IR/MDR/A/B/ALUOut
// holding registers. This block steps each instruction through
// FETCH -> DECODE -> execute -> memory -> write-back and drives every mux
// select and write strobe in the datapath.
//
// Ports
//   clk         in   single clock, rising-edge
//   reset       in   synchronous, active-low
//   opcode      in   IR[6:0] of the latched instruction
//   bcond       in   branch-compare result, meaningful in EX_BR
//   ecall_halt  in   datapath flag (x17 == 10), selects a halting ECALL
//   mem_ready   in   memory completes the current read/write this cycle
//   pc_write    out  load PC this edge
//   pc_source   out  0 = live ALU result, 1 = ALUOut register
//   i_or_d      out  memory address: 0 = PC, 1 = ALUOut
//   mem_read    out  memory read request
//   mem_write   out  memory write request
//   ir_write    out  latch memory dout into IR
//   reg_write   out  register-file write enable
//   mem_to_reg  out  rd_din = MDR
//   pc_to_reg   out  rd_din = live ALU result (PC+4 for link)
//   alu_src_a   out  0 = PC, 1 = A
//   alu_src_b   out  0 = B, 1 = constant 4, 2 = immediate
//   alu_op      out  0 = add, 1 = branch compare, 2 = decode funct3/funct7
//   is_halted   out  high once a halting ECALL has been decoded
// -----------------------------------------------------------------------------
module multi_cycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       ecall_halt,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       pc_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       is_halted
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [1:0] SRC_B_REG  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_BRANCH = 2'd1;
  localparam logic [1:0] ALU_FUNCT  = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_I    = 4'd3,
    S_EX_ADDR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_ALU  = 4'd7,
    S_WB_MEM  = 4'd8,
    S_EX_BR   = 4'd9,
    S_EX_JAL  = 4'd10,
    S_EX_JALR = 4'd11,
    S_JALR_WB = 4'd12,
    S_PC_INC  = 4'd13,
    S_HALT    = 4'd14
  } state_t;

  state_t state_q, state_d;

  // State register; reset returns to FETCH from anywhere, including HALT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_R:      state_d = S_EX_R;
          OP_I_ALU:  state_d = S_EX_I;
          OP_LOAD:   state_d = S_EX_ADDR;
          OP_STORE:  state_d = S_EX_ADDR;
          OP_BRANCH: state_d = S_EX_BR;
          OP_JAL:    state_d = S_EX_JAL;
          OP_JALR:   state_d = S_EX_JALR;
          OP_ECALL:  state_d = ecall_halt ? S_HALT : S_PC_INC;
          default:   state_d = S_PC_INC;
        endcase
      end
      S_EX_R:    state_d = S_WB_ALU;
      S_EX_I:    state_d = S_WB_ALU;
      // Only LOAD and STORE reach EX_ADDR, so anything not a store is a load.
      S_EX_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_WB_ALU:  state_d = S_FETCH;
      S_WB_MEM:  state_d = S_FETCH;
      S_EX_BR:   state_d = bcond ? S_FETCH : S_PC_INC;
      S_EX_JAL:  state_d = S_FETCH;
      S_EX_JALR: state_d = S_JALR_WB;
      S_JALR_WB: state_d = S_FETCH;
      S_PC_INC:  state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode. Moore from state, except ir_write (FETCH & mem_ready) and
  // pc_write in MEM_WR / EX_BR. Everything is held at 0 while reset is low,
  // so a reset during a memory wait drops the request in that same cycle.
  always_comb begin
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    alu_op     = ALU_ADD;
    is_halted  = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
        end
        S_DECODE: begin
          // PC+imm precomputed into ALUOut for branch/JAL targets.
          alu_src_b = SRC_B_IMM;
        end
        S_EX_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_EX_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_FUNCT;
        end
        S_EX_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
        end
        S_MEM_RD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
        end
        S_MEM_WR: begin
          // PC+4 is applied on the edge the store completes.
          i_or_d    = 1'b1;
          mem_write = 1'b1;
          alu_src_b = SRC_B_FOUR;
          pc_write  = mem_ready;
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
          alu_src_b = SRC_B_FOUR;
          pc_write  = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          alu_src_b  = SRC_B_FOUR;
          pc_write   = 1'b1;
        end
        S_EX_BR: begin
          // Target sits in ALUOut from DECODE; the ALU is busy comparing.
          alu_src_a = 1'b1;
          alu_op    = ALU_BRANCH;
          pc_source = 1'b1;
          pc_write  = bcond;
        end
        S_EX_JAL, S_JALR_WB: begin
          // Link value PC+4 comes live from the ALU; target from ALUOut.
          alu_src_b = SRC_B_FOUR;
          pc_to_reg = 1'b1;
          reg_write = 1'b1;
          pc_write  = 1'b1;
          pc_source = 1'b1;
        end
        S_EX_JALR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
        end
        S_PC_INC: begin
          alu_src_b = SRC_B_FOUR;
          pc_write  = 1'b1;
        end
        S_HALT: begin
          is_halted = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       bcond;
  logic       ecall_halt;
  logic       mem_ready;
  logic       pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_write, mem_to_reg, pc_to_reg, alu_src_a, is_halted;
  logic [1:0] alu_src_b, alu_op;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_cycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
    .ecall_halt(ecall_halt), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .is_halted(is_halted)
  );

  // Bundle order: pw ps iod mr mw irw rw m2r p2r asa asb[1:0] aop[1:0] halt
  localparam logic [14:0] E_ZERO     = 15'b0_0_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [14:0] E_FETCH_R  = 15'b0_0_0_1_0_1_0_0_0_0_00_00_0;
  localparam logic [14:0] E_FETCH_W  = 15'b0_0_0_1_0_0_0_0_0_0_00_00_0;
  localparam logic [14:0] E_DECODE   = 15'b0_0_0_0_0_0_0_0_0_0_10_00_0;
  localparam logic [14:0] E_EX_R     = 15'b0_0_0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [14:0] E_EX_I     = 15'b0_0_0_0_0_0_0_0_0_1_10_10_0;
  localparam logic [14:0] E_EX_ADDR  = 15'b0_0_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [14:0] E_MEM_RD   = 15'b0_0_1_1_0_0_0_0_0_0_00_00_0;
  localparam logic [14:0] E_MEM_WR_W = 15'b0_0_1_0_1_0_0_0_0_0_01_00_0;
  localparam logic [14:0] E_MEM_WR_R = 15'b1_0_1_0_1_0_0_0_0_0_01_00_0;
  localparam logic [14:0] E_WB_ALU   = 15'b1_0_0_0_0_0_1_0_0_0_01_00_0;
  localparam logic [14:0] E_WB_MEM   = 15'b1_0_0_0_0_0_1_1_0_0_01_00_0;
  localparam logic [14:0] E_BR_T     = 15'b1_1_0_0_0_0_0_0_0_1_00_01_0;
  localparam logic [14:0] E_BR_NT    = 15'b0_1_0_0_0_0_0_0_0_1_00_01_0;
  localparam logic [14:0] E_JAL      = 15'b1_1_0_0_0_0_1_0_1_0_01_00_0;
  localparam logic [14:0] E_EX_JALR  = 15'b0_0_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [14:0] E_PC_INC   = 15'b1_0_0_0_0_0_0_0_0_0_01_00_0;
  localparam logic [14:0] E_HALT     = 15'b0_0_0_0_0_0_0_0_0_0_00_00_1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  // Move past the next rising edge; inputs set afterwards apply to that cycle.
  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  // Let combinational outputs settle, then compare the whole output bundle.
  task automatic chk(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    #1;
    obs = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_write, mem_to_reg, pc_to_reg, alu_src_a, alu_src_b, alu_op,
           is_halted};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; opcode = OP_R; bcond = 1'b0; ecall_halt = 1'b0; mem_ready = 1'b1;

    // Reset held for three edges; outputs forced low even with mem_ready=1.
    adv(); chk("rst_c1", E_ZERO);
    adv(); chk("rst_c2", E_ZERO);
    adv(); chk("rst_c3", E_ZERO);

    // R-type: 4 cycles, reg_write and pc_write only in cycle 4.
    reset = 1'b1;
    chk("r_fetch", E_FETCH_R);
    adv(); chk("r_decode", E_DECODE);
    adv(); chk("r_ex", E_EX_R);
    adv(); chk("r_wb", E_WB_ALU);

    // I-ALU
    adv(); opcode = OP_I; chk("i_fetch", E_FETCH_R);
    adv(); chk("i_decode", E_DECODE);
    adv(); chk("i_ex", E_EX_I);
    adv(); chk("i_wb", E_WB_ALU);

    // LOAD with two wait cycles in MEM_RD: 7 cycles total.
    adv(); opcode = OP_LOAD; chk("ld_fetch", E_FETCH_R);
    adv(); chk("ld_decode", E_DECODE);
    adv(); chk("ld_addr", E_EX_ADDR);
    adv(); mem_ready = 1'b0; chk("ld_wait1", E_MEM_RD);
    adv(); chk("ld_wait2", E_MEM_RD);
    adv(); mem_ready = 1'b1; chk("ld_memrd", E_MEM_RD);
    adv(); chk("ld_wbmem", E_WB_MEM);

    // STORE with one wait cycle in FETCH.
    adv(); opcode = OP_STORE; mem_ready = 1'b0; chk("st_fetch_wait", E_FETCH_W);
    adv(); mem_ready = 1'b1; chk("st_fetch", E_FETCH_R);
    adv(); chk("st_decode", E_DECODE);
    adv(); chk("st_addr", E_EX_ADDR);
    adv(); chk("st_memwr", E_MEM_WR_R);

    // BRANCH taken, mem_ready low in DECODE (ignored there).
    adv(); opcode = OP_BRANCH; chk("bt_fetch", E_FETCH_R);
    adv(); mem_ready = 1'b0; chk("bt_decode", E_DECODE);
    adv(); mem_ready = 1'b1; bcond = 1'b1; chk("bt_exbr", E_BR_T);

    // BRANCH not taken: PC_INC writes in cycle 4.
    adv(); bcond = 1'b0; chk("bn_fetch", E_FETCH_R);
    adv(); chk("bn_decode", E_DECODE);
    adv(); chk("bn_exbr", E_BR_NT);
    adv(); chk("bn_pcinc", E_PC_INC);

    // JAL
    adv(); opcode = OP_JAL; chk("jal_fetch", E_FETCH_R);
    adv(); chk("jal_decode", E_DECODE);
    adv(); chk("jal_ex", E_JAL);

    // JALR
    adv(); opcode = OP_JALR; chk("jalr_fetch", E_FETCH_R);
    adv(); chk("jalr_decode", E_DECODE);
    adv(); chk("jalr_ex", E_EX_JALR);
    adv(); chk("jalr_wb", E_JAL);

    // Unknown opcode acts as a NOP.
    adv(); opcode = OP_NOP; chk("nop_fetch", E_FETCH_R);
    adv(); chk("nop_decode", E_DECODE);
    adv(); chk("nop_pcinc", E_PC_INC);

    // Non-halting ECALL
    adv(); opcode = OP_ECALL; ecall_halt = 1'b0; chk("ec_fetch", E_FETCH_R);
    adv(); chk("ec_decode", E_DECODE);
    adv(); chk("ec_pcinc", E_PC_INC);

    // Halting ECALL: is_halted from cycle 3, absorbing.
    adv(); ecall_halt = 1'b1; chk("eh_fetch", E_FETCH_R);
    adv(); chk("eh_decode", E_DECODE);
    adv(); chk("eh_halt1", E_HALT);
    adv(); opcode = OP_R; chk("eh_halt2", E_HALT);
    adv(); chk("eh_halt3", E_HALT);
    reset = 1'b0; chk("eh_rst", E_ZERO);
    adv(); reset = 1'b1; ecall_halt = 1'b0; chk("eh_after_rst", E_FETCH_R);

    // STORE with reset pulled low during the MEM_WR wait.
    opcode = OP_STORE;
    adv(); chk("sr_decode", E_DECODE);
    adv(); chk("sr_addr", E_EX_ADDR);
    adv(); mem_ready = 1'b0; chk("sr_wait", E_MEM_WR_W);
    reset = 1'b0; mem_ready = 1'b1; chk("sr_rst", E_ZERO);
    adv(); reset = 1'b1; mem_ready = 1'b0; chk("sr_after_rst", E_FETCH_W);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
